// File: rtl/seg_display_sched_if.sv
// Bundle between the display requesters and the seven-segment scheduler.
// The slave modport is the scheduler side.
interface seg_display_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*16-1:0] req_data;
  logic                  lock;
  logic [15:0]           disp_data;
  logic                  disp_valid;
  logic [NUM_REQ-1:0]    grant;
  logic [OW-1:0]         owner;
  logic                  switch_pulse;

  modport master (
    output req, req_data, lock,
    input  disp_data, disp_valid, grant, owner, switch_pulse
  );

  modport slave (
    input  req, req_data, lock,
    output disp_data, disp_valid, grant, owner, switch_pulse
  );
endinterface

// File: rtl/seg_display_sched.sv
// Round-robin owner scheduler for the shared 4-digit seven-segment display,
// with a minimum dwell per owner and a lock that freezes the current owner.
module seg_display_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input logic               clk,
  input logic               rst,
  seg_display_sched_if.slave bus
);
  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned DW = $clog2(HOLD_CYCLES);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t             state_q, state_n;
  logic [OW-1:0]      owner_q, owner_n;
  logic [OW-1:0]      ptr_q, ptr_n;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic [DW-1:0]      dwell_q, dwell_n;
  logic [15:0]        data_q, data_n;
  logic               valid_q, valid_n;
  logic               pulse_q, pulse_n;

  logic [15:0]        data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] cand;
  logic               pick_found;
  logic [OW-1:0]      pick_idx;
  logic               req_own;
  logic               expired;
  logic               take;

  function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base,
                                             input int unsigned    k);
    int unsigned s;
    s = 32'(base) + k;
    return OW'(s % NUM_REQ);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = bus.req_data[16*g +: 16];
  end

  // Current owner never competes in its own re-arbitration.
  assign cand    = bus.req & ~grant_q;
  assign req_own = bus.req[owner_q];
  assign expired = (dwell_q == DW'(HOLD_CYCLES - 1));

  // First candidate at or after the round-robin pointer, with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && cand[wrap_idx(ptr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_n = state_q;
    owner_n = owner_q;
    ptr_n   = ptr_q;
    grant_n = grant_q;
    dwell_n = dwell_q;
    data_n  = data_q;
    valid_n = valid_q;
    pulse_n = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) take = 1'b1;
      end
      SHOW: begin
        data_n = data_arr[owner_q];
        if (!req_own || (expired && !bus.lock)) begin
          if (pick_found) begin
            take = 1'b1;
          end else if (!req_own) begin
            state_n = IDLE;
            grant_n = '0;
            valid_n = 1'b0;
          end else begin
            dwell_n = '0;
          end
        end else if (!expired) begin
          // Held at expiry value while locked, so release acts on the next edge.
          dwell_n = dwell_q + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (take) begin
      state_n           = SHOW;
      owner_n           = pick_idx;
      ptr_n             = wrap_idx(pick_idx, 1);
      grant_n           = '0;
      grant_n[pick_idx] = 1'b1;
      dwell_n           = '0;
      valid_n           = 1'b1;
      pulse_n           = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      dwell_q <= '0;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_n;
      owner_q <= owner_n;
      ptr_q   <= ptr_n;
      grant_q <= grant_n;
      dwell_q <= dwell_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      pulse_q <= pulse_n;
    end
  end

  assign bus.disp_data    = data_q;
  assign bus.disp_valid   = valid_q;
  assign bus.grant        = grant_q;
  assign bus.owner        = owner_q;
  assign bus.switch_pulse = pulse_q;
endmodule

// File: tb/tb_seg_display_sched.sv
// Self-checking bench for seg_display_sched: directed vector table, hand-written
// lock/drop/reset sequences, then random traffic against a behavioural model.
module tb_seg_display_sched;
  localparam int unsigned N    = 4;
  localparam int unsigned HOLD = 4;

  localparam logic [63:0] D0 = {16'h0000, 16'hABCD, 16'h0000, 16'h1234};
  localparam logic [63:0] D1 = {16'h0001, 16'hABCD, 16'h0000, 16'h1234};
  localparam logic [63:0] D2 = {16'h0002, 16'hABCD, 16'h0000, 16'h1234};

  typedef struct packed {
    logic [3:0]  req;
    logic        lock;
    logic [63:0] rdata;
    logic [3:0]  e_grant;
    logic        e_pulse;
    logic [15:0] e_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic        lock = 1'b0;
  logic [63:0] rdata = '0;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model state
  bit          m_busy;
  bit          m_fresh;
  int          m_owner;
  int          m_age;
  logic [15:0] m_data;
  bit          m_pulse;

  seg_display_sched_if #(.NUM_REQ(N)) bus ();

  assign bus.req      = req;
  assign bus.req_data = rdata;
  assign bus.lock     = lock;

  seg_display_sched #(.NUM_REQ(N), .HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_pick(input logic [3:0] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_busy  = 0;
    m_fresh = 1;
    m_owner = 0;
    m_age   = 0;
    m_data  = 16'h0000;
    m_pulse = 0;
  endtask

  task automatic m_grant(input int c);
    m_busy  = 1;
    m_fresh = 0;
    m_owner = c;
    m_age   = 0;
    m_pulse = 1;
  endtask

  // One clock of the display-sharing rules, applied to the inputs held before the edge.
  task automatic m_step();
    int c;
    int start;
    start   = m_fresh ? 0 : (m_owner + 1) % N;
    m_pulse = 0;
    if (!m_busy) begin
      c = m_pick(req, start, -1);
      if (c >= 0) m_grant(c);
    end else begin
      m_data = rdata[m_owner*16 +: 16];
      if (!req[m_owner]) begin
        c = m_pick(req, start, m_owner);
        if (c >= 0) m_grant(c);
        else m_busy = 0;
      end else if (m_age >= HOLD - 1 && !lock) begin
        c = m_pick(req, start, m_owner);
        if (c >= 0) m_grant(c);
        else m_age = 0;
      end else if (m_age < HOLD - 1) begin
        m_age++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) m_step();
    #1;
  endtask

  task automatic chk_model(input string tag);
    logic [3:0] eg;
    eg = m_busy ? 4'(1 << m_owner) : 4'b0000;
    chk({tag, ".grant"}, 32'(bus.grant), 32'(eg));
    chk({tag, ".valid"}, 32'(bus.disp_valid), 32'(m_busy));
    chk({tag, ".owner"}, 32'(bus.owner), 32'(m_owner));
    chk({tag, ".data"},  32'(bus.disp_data), 32'(m_data));
    chk({tag, ".pulse"}, 32'(bus.switch_pulse), 32'(m_pulse));
  endtask

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{4'b0101, 1'b0, D0, 4'b0001, 1'b1, 16'h0000};
    tbl[1]  = '{4'b0101, 1'b0, D0, 4'b0001, 1'b0, 16'h1234};
    tbl[2]  = '{4'b0101, 1'b0, D0, 4'b0001, 1'b0, 16'h1234};
    tbl[3]  = '{4'b0101, 1'b0, D0, 4'b0001, 1'b0, 16'h1234};
    tbl[4]  = '{4'b0101, 1'b0, D0, 4'b0100, 1'b1, 16'h1234};
    tbl[5]  = '{4'b0101, 1'b0, D0, 4'b0100, 1'b0, 16'hABCD};
    tbl[6]  = '{4'b0101, 1'b0, D0, 4'b0100, 1'b0, 16'hABCD};
    tbl[7]  = '{4'b0101, 1'b0, D0, 4'b0100, 1'b0, 16'hABCD};
    tbl[8]  = '{4'b0101, 1'b0, D0, 4'b0001, 1'b1, 16'hABCD};
    tbl[9]  = '{4'b0101, 1'b0, D0, 4'b0001, 1'b0, 16'h1234};
    tbl[10] = '{4'b1000, 1'b0, D0, 4'b1000, 1'b1, 16'h1234};
    tbl[11] = '{4'b1000, 1'b0, D1, 4'b1000, 1'b0, 16'h0001};
    tbl[12] = '{4'b1000, 1'b0, D2, 4'b1000, 1'b0, 16'h0002};
    tbl[13] = '{4'b1000, 1'b0, D2, 4'b1000, 1'b0, 16'h0002};
    tbl[14] = '{4'b1000, 1'b0, D2, 4'b1000, 1'b0, 16'h0002};
    tbl[15] = '{4'b1000, 1'b0, D2, 4'b1000, 1'b0, 16'h0002};

    m_reset();
    repeat (2) cycle();
    chk("rst.grant", 32'(bus.grant), 32'h0);
    chk("rst.valid", 32'(bus.disp_valid), 32'h0);
    chk("rst.owner", 32'(bus.owner), 32'h0);
    chk("rst.data",  32'(bus.disp_data), 32'h0);
    chk("rst.pulse", 32'(bus.switch_pulse), 32'h0);
    rst = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle.valid", 32'(bus.disp_valid), 32'h0);
      chk("idle.grant", 32'(bus.grant), 32'h0);
      chk("idle.data",  32'(bus.disp_data), 32'h0);
      chk("idle.pulse", 32'(bus.switch_pulse), 32'h0);
    end

    // Directed vectors: rotation between 0 and 2, then lone owner 3 with live data
    for (int i = 0; i < 16; i++) begin
      req   = tbl[i].req;
      lock  = tbl[i].lock;
      rdata = tbl[i].rdata;
      cycle();
      chk($sformatf("tbl%0d.grant", i), 32'(bus.grant), 32'(tbl[i].e_grant));
      chk($sformatf("tbl%0d.pulse", i), 32'(bus.switch_pulse), 32'(tbl[i].e_pulse));
      chk($sformatf("tbl%0d.data", i),  32'(bus.disp_data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d.valid", i), 32'(bus.disp_valid), 32'(|tbl[i].e_grant));
    end

    // Lock freezes owner 0 despite a competing request; release switches next edge
    req = 4'b0001; rdata = D0;
    cycle();
    chk("lk.grant0", 32'(bus.grant), 32'h1);
    chk("lk.pulse0", 32'(bus.switch_pulse), 32'h1);
    req = 4'b0011; lock = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("lk.hold", 32'({bus.grant, bus.switch_pulse}), 32'({4'b0001, 1'b0}));
    end
    lock = 1'b0;
    cycle();
    chk("lk.grant1", 32'(bus.grant), 32'h2);
    chk("lk.pulse1", 32'(bus.switch_pulse), 32'h1);

    // Owner 1 drops its request while locked: go idle, keep owner and data
    rdata = {16'h0000, 16'hABCD, 16'h5555, 16'h1234};
    req = 4'b0010; lock = 1'b1;
    repeat (2) cycle();
    chk("drop.pre_data", 32'(bus.disp_data), 32'h5555);
    req = 4'b0000;
    cycle();
    chk("drop.grant", 32'(bus.grant), 32'h0);
    chk("drop.valid", 32'(bus.disp_valid), 32'h0);
    chk("drop.owner", 32'(bus.owner), 32'h1);
    chk("drop.pulse", 32'(bus.switch_pulse), 32'h0);
    chk("drop.data",  32'(bus.disp_data), 32'h5555);
    rdata = {16'h0000, 16'hABCD, 16'h7777, 16'h1234};
    cycle();
    chk("drop.hold_data", 32'(bus.disp_data), 32'h5555);

    // Owner 2 granted, then asynchronous reset mid-dwell
    req = 4'b0100; lock = 1'b0;
    cycle();
    chk("ar.grant2", 32'(bus.grant), 32'h4);
    chk("ar.pulse2", 32'(bus.switch_pulse), 32'h1);
    cycle();
    rst = 1'b1;
    #1;
    chk("ar.grant", 32'(bus.grant), 32'h0);
    chk("ar.valid", 32'(bus.disp_valid), 32'h0);
    chk("ar.owner", 32'(bus.owner), 32'h0);
    chk("ar.data",  32'(bus.disp_data), 32'h0);
    chk("ar.pulse", 32'(bus.switch_pulse), 32'h0);
    m_reset();
    req = 4'b1111;
    cycle();
    chk("ar.held_pulse", 32'(bus.switch_pulse), 32'h0);
    rst = 1'b0;
    cycle();
    chk("ar.first_grant", 32'(bus.grant), 32'h1);
    chk("ar.first_pulse", 32'(bus.switch_pulse), 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) lock = ~lock;
      rdata = {$urandom, $urandom};
      cycle();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seg_display_sched.md
Name: seg_display_sched

Overview:
Time-multiplexing scheduler that shares the 4-digit seven-segment display between several 16-bit data requesters (CPU confreg write value, debug PC, switch state, etc.). It grants display ownership round-robin with a minimum dwell time. It supports a lock to freeze the current owner. It drives the 16-bit data input of the seven-segment driver and reports the current owner for LED indication.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
HOLD_CYCLES, 50000000, dwell time per owner in clk cycles (>=2)
OW, $clog2(NUM_REQ), owner index width (derived, not overridable)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req  input  NUM_REQ  level request; bit i high = requester i has data to show
req_data  input  NUM_REQ*16  requester i data in bits [16*i+15:16*i]
lock  input  1  level; freezes current owner while high
disp_data  output  16  data to seven-segment driver, registered
disp_valid  output  1  high while an owner is granted (SHOW)
grant  output  NUM_REQ  one-hot current owner, all-zero in IDLE
owner  output  OW  binary index of current owner (last owner in IDLE)
switch_pulse  output  1  one-cycle pulse on every ownership change, including IDLE->SHOW

Behaviour:
- Reset (async, rst=1): state=IDLE, grant=0, owner=0, disp_data=16'h0000, disp_valid=0, switch_pulse=0, dwell=0, rr pointer set so first search starts at index 0.
- Round-robin pick: first i with req[i]=1, searching from (owner+1) mod NUM_REQ upward with wrap. After reset, search starts at 0.
- States: IDLE, SHOW.
- IDLE: if |req, pick next owner. Next cycle: state=SHOW, grant/owner updated, dwell=0, switch_pulse=1. Otherwise hold outputs; disp_data keeps its last value.
- SHOW: disp_data <= req_data[owner] every cycle (live tracking, 1-cycle latency). disp_valid=1. dwell increments each cycle.
- Dwell expiry (dwell==HOLD_CYCLES-1, lock=0):
  - another requester active: switch to round-robin pick, dwell=0, switch_pulse=1.
  - only owner requesting: keep owner, dwell=0, no pulse.
- Owner drops req in SHOW, regardless of dwell or lock: next cycle re-arbitrate among remaining requests.
  - if any remain: switch with pulse.
  - if none: IDLE, grant=0, disp_valid=0, no pulse. owner and disp_data retain their values.
- lock=1 with owner requesting: dwell saturates at HOLD_CYCLES-1; no switch. On lock release with dwell saturated, switch decision occurs that same cycle (effective next edge).
- Simultaneous expiry and owner drop: treated as owner drop; owner is excluded from the pick.
- req changes of non-owners never disturb the current owner before expiry.
- grant is always one-hot or zero; owner==index of the grant bit whenever disp_valid=1.
- Mid-operation reset returns immediately to the reset values; no pulse is generated.

Test Plan:
1. Reset, req=4'b0000 for 10 cycles -> disp_valid=0, grant=0, disp_data=16'h0000, no switch_pulse.
2. HOLD_CYCLES=4, req=4'b0101, data0=16'h1234, data2=16'hABCD:
   - cycle 1 after req: grant=0001, pulse, disp_data=1234 one cycle later.
   - after 4 cycles: grant=0100, pulse, disp_data=ABCD.
   - then back to 0001.
3. Only req[3]=1, data3 changing 16'h0001->16'h0002 mid-dwell -> grant stays 1000, no pulse at expiry, disp_data follows with 1-cycle latency.
4. Owner 0 granted, req=4'b0011, lock=1 for 20 cycles -> grant stays 0001; drop lock -> grant=0010 with pulse on the next edge.
5. Owner 1 granted with req=4'b0010, drop req[1] mid-dwell (lock=1) -> next cycle IDLE, grant=0, disp_valid=0, owner=1, disp_data retains last value.
6. Owner 2 granted, assert rst mid-dwell -> all outputs return to reset values asynchronously; after release with req=4'b1111, first grant=0001.
